// File: rtl/torreta_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : torreta_pkg
//  Description : Shared constants, FSM state encoding and the BCD-to-ASCII
//                helper for the turret measurement formatter.
//                Contents:
//                  ASCII_ZERO, ASCII_ESPACO, ASCII_VIRGULA, ASCII_CERQUILHA
//                  DISTANCIA_MAX      distance saturation value (cm)
//                  estado_t           formatter FSM states
//                  bcd_para_ascii()   BCD nibble -> 7-bit ASCII digit
//  Revision    : 1.0 - initial release
// ============================================================================
package torreta_pkg;

  localparam logic [6:0] ASCII_ZERO      = 7'h30;
  localparam logic [6:0] ASCII_ESPACO    = 7'h20;
  localparam logic [6:0] ASCII_VIRGULA   = 7'h2C;
  localparam logic [6:0] ASCII_CERQUILHA = 7'h23;

  localparam int DISTANCIA_MAX = 999;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    DESLOCA = 3'd2,
    FORMATA = 3'd3,
    FIM     = 3'd4
  } estado_t;

  function automatic logic [6:0] bcd_para_ascii(input logic [3:0] nibble);
    return ASCII_ZERO + {3'b000, nibble};
  endfunction

endpackage
`default_nettype wire

// File: rtl/conversor_binario_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : conversor_binario_bcd
//  Description : Iterative shift-add-3 (double-dabble) binary to 3-digit BCD
//                converter. One iteration per cycle while desloca is high.
//  Ports       :
//    clock    in   system clock
//    reset    in   synchronous, active-high reset
//    carrega  in   load valor into the shift register and clear the BCD
//    desloca  in   perform one add-3/shift iteration
//    valor    in   [LARGURA] binary value to convert
//    centena  out  [4] hundreds BCD digit
//    dezena   out  [4] tens BCD digit
//    unidade  out  [4] units BCD digit
//  Revision    : 1.0 - initial release
// ============================================================================
module conversor_binario_bcd
  import torreta_pkg::*;
#(
  parameter int LARGURA = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic               desloca,
  input  logic [LARGURA-1:0] valor,
  output logic [3:0]         centena,
  output logic [3:0]         dezena,
  output logic [3:0]         unidade
);

  logic [LARGURA-1:0] bin_q, bin_d;
  logic [11:0]        bcd_q, bcd_d;
  logic [11:0]        bcd_ajustado;

  always_comb begin
    // Add-3 correction is applied before the shift so that no nibble
    // overflows past 9 after doubling.
    bcd_ajustado = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_ajustado[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    bin_d = bin_q;
    bcd_d = bcd_q;
    if (carrega) begin
      bin_d = valor;
      bcd_d = '0;
    end else if (desloca) begin
      {bcd_d, bin_d} = {bcd_ajustado[10:0], bin_q, 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  assign centena = bcd_q[11:8];
  assign dezena  = bcd_q[7:4];
  assign unidade = bcd_q[3:0];

endmodule
`default_nettype wire

// File: rtl/formatador_ascii_medida.sv
`default_nettype none
// ============================================================================
//  Module      : formatador_ascii_medida
//  Description : Latches an angle and a distance, converts each to three
//                ASCII decimal digits and pulses pronto for one cycle when
//                the digits are valid. Feeds the ASCII serial transmitter.
//  Build macro : SUPRESSAO_ZEROS_EN - when defined, leading zeros of the
//                hundreds/tens digits are printed as spaces.
//  Ports       :
//    clock                       in   system clock
//    reset                       in   synchronous, active-high reset
//    converter                   in   start request (sampled in OCIOSO)
//    angulo                      in   [8] angle, degrees
//    distancia                   in   [LARGURA_DIST] distance, cm
//    centena/dezena/unidade_angulo      out [7] angle ASCII digits
//    caractere_final_angulo      out  [7] constant ','
//    centena/dezena/unidade_distancia   out [7] distance ASCII digits
//    caractere_final_distancia   out  [7] constant '#'
//    ocupado                     out  high whenever not idle
//    pronto                      out  one-cycle pulse, digits valid
//  Revision    : 1.0 - initial release
// ============================================================================
module formatador_ascii_medida
  import torreta_pkg::*;
#(
  parameter int LARGURA_DIST = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    converter,
  input  logic [7:0]              angulo,
  input  logic [LARGURA_DIST-1:0] distancia,
  output logic [6:0]              centena_angulo,
  output logic [6:0]              dezena_angulo,
  output logic [6:0]              unidade_angulo,
  output logic [6:0]              caractere_final_angulo,
  output logic [6:0]              centena_distancia,
  output logic [6:0]              dezena_distancia,
  output logic [6:0]              unidade_distancia,
  output logic [6:0]              caractere_final_distancia,
  output logic                    ocupado,
  output logic                    pronto
);

  localparam logic [LARGURA_DIST-1:0] DIST_MAX_L   = LARGURA_DIST'(DISTANCIA_MAX);
  localparam logic [3:0]              ULTIMA_ITER  = 4'(LARGURA_DIST - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] iter_q, iter_d;
  logic       carrega, desloca;

  logic [LARGURA_DIST-1:0] angulo_ext, distancia_sat;

  logic [3:0] c_ang, d_ang, u_ang, c_dst, d_dst, u_dst;
  logic [6:0] fmt_c_ang, fmt_d_ang, fmt_u_ang, fmt_c_dst, fmt_d_dst, fmt_u_dst;
  logic [6:0] c_ang_q, d_ang_q, u_ang_q, c_dst_q, d_dst_q, u_dst_q;
  logic [6:0] c_ang_d, d_ang_d, u_ang_d, c_dst_d, d_dst_d, u_dst_d;

  assign angulo_ext    = LARGURA_DIST'(angulo);
  assign distancia_sat = (distancia > DIST_MAX_L) ? DIST_MAX_L : distancia;

  conversor_binario_bcd #(.LARGURA(LARGURA_DIST)) u_conv_angulo (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega),
    .desloca (desloca),
    .valor   (angulo_ext),
    .centena (c_ang),
    .dezena  (d_ang),
    .unidade (u_ang)
  );

  conversor_binario_bcd #(.LARGURA(LARGURA_DIST)) u_conv_distancia (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega),
    .desloca (desloca),
    .valor   (distancia_sat),
    .centena (c_dst),
    .dezena  (d_dst),
    .unidade (u_dst)
  );

  // ASCII formatting of the BCD digits
  always_comb begin
    fmt_c_ang = bcd_para_ascii(c_ang);
    fmt_d_ang = bcd_para_ascii(d_ang);
    fmt_u_ang = bcd_para_ascii(u_ang);
    fmt_c_dst = bcd_para_ascii(c_dst);
    fmt_d_dst = bcd_para_ascii(d_dst);
    fmt_u_dst = bcd_para_ascii(u_dst);
`ifdef SUPRESSAO_ZEROS_EN
    // The tens digit is only blanked when the hundreds digit is also blank.
    if (c_ang == 4'd0) begin
      fmt_c_ang = ASCII_ESPACO;
      if (d_ang == 4'd0) fmt_d_ang = ASCII_ESPACO;
    end
    if (c_dst == 4'd0) begin
      fmt_c_dst = ASCII_ESPACO;
      if (d_dst == 4'd0) fmt_d_dst = ASCII_ESPACO;
    end
`endif
  end

  // FSM next state, datapath controls and Moore outputs
  always_comb begin
    estado_d = estado_q;
    iter_d   = iter_q;
    carrega  = 1'b0;
    desloca  = 1'b0;
    ocupado  = 1'b1;
    pronto   = 1'b0;
    c_ang_d  = c_ang_q;
    d_ang_d  = d_ang_q;
    u_ang_d  = u_ang_q;
    c_dst_d  = c_dst_q;
    d_dst_d  = d_dst_q;
    u_dst_d  = u_dst_q;

    case (estado_q)
      OCIOSO: begin
        ocupado = 1'b0;
        if (converter) estado_d = CARREGA;
      end
      CARREGA: begin
        carrega  = 1'b1;
        iter_d   = 4'd0;
        estado_d = DESLOCA;
      end
      DESLOCA: begin
        desloca = 1'b1;
        iter_d  = iter_q + 4'd1;
        if (iter_q == ULTIMA_ITER) estado_d = FORMATA;
      end
      FORMATA: begin
        c_ang_d  = fmt_c_ang;
        d_ang_d  = fmt_d_ang;
        u_ang_d  = fmt_u_ang;
        c_dst_d  = fmt_c_dst;
        d_dst_d  = fmt_d_dst;
        u_dst_d  = fmt_u_dst;
        estado_d = FIM;
      end
      FIM: begin
        pronto   = 1'b1;
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      iter_q   <= 4'd0;
      c_ang_q  <= ASCII_ZERO;
      d_ang_q  <= ASCII_ZERO;
      u_ang_q  <= ASCII_ZERO;
      c_dst_q  <= ASCII_ZERO;
      d_dst_q  <= ASCII_ZERO;
      u_dst_q  <= ASCII_ZERO;
    end else begin
      estado_q <= estado_d;
      iter_q   <= iter_d;
      c_ang_q  <= c_ang_d;
      d_ang_q  <= d_ang_d;
      u_ang_q  <= u_ang_d;
      c_dst_q  <= c_dst_d;
      d_dst_q  <= d_dst_d;
      u_dst_q  <= u_dst_d;
    end
  end

  assign centena_angulo            = c_ang_q;
  assign dezena_angulo             = d_ang_q;
  assign unidade_angulo            = u_ang_q;
  assign caractere_final_angulo    = ASCII_VIRGULA;
  assign centena_distancia         = c_dst_q;
  assign dezena_distancia          = d_dst_q;
  assign unidade_distancia         = u_dst_q;
  assign caractere_final_distancia = ASCII_CERQUILHA;

endmodule
`default_nettype wire

// File: tb/tb_formatador_ascii_medida.sv
`default_nettype none
// ============================================================================
//  Module      : tb_formatador_ascii_medida
//  Description : Scoreboard bench for formatador_ascii_medida. Expected
//                output words are queued at request time; a monitor pops and
//                compares on every pronto pulse. Honours SUPRESSAO_ZEROS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_formatador_ascii_medida;

  localparam int LD = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          converter = 1'b0;
  logic [7:0]    angulo = '0;
  logic [LD-1:0] distancia = '0;
  logic [6:0]    c_a, d_a, u_a, f_a, c_d, d_d, u_d, f_d;
  logic          ocupado, pronto;

  int tests = 0;
  int fails = 0;

  logic [55:0] sb_q[$];

  formatador_ascii_medida #(.LARGURA_DIST(LD)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .converter                 (converter),
    .angulo                    (angulo),
    .distancia                 (distancia),
    .centena_angulo            (c_a),
    .dezena_angulo             (d_a),
    .unidade_angulo            (u_a),
    .caractere_final_angulo    (f_a),
    .centena_distancia         (c_d),
    .dezena_distancia          (d_d),
    .unidade_distancia         (u_d),
    .caractere_final_distancia (f_d),
    .ocupado                   (ocupado),
    .pronto                    (pronto)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor
  always @(negedge clock) begin
    if (pronto) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pronto: got pronto=1 with no pending request, required none");
      end else begin
        logic [55:0] exp_w, got_w;
        exp_w = sb_q.pop_front();
        got_w = {c_a, d_a, u_a, f_a, c_d, d_d, u_d, f_d};
        if (got_w !== exp_w) begin
          fails++;
          $display("FAIL digits: got %h %h %h %h / %h %h %h %h, required %h %h %h %h / %h %h %h %h",
                   c_a, d_a, u_a, f_a, c_d, d_d, u_d, f_d,
                   exp_w[55:49], exp_w[48:42], exp_w[41:35], exp_w[34:28],
                   exp_w[27:21], exp_w[20:14], exp_w[13:7], exp_w[6:0]);
        end
      end
    end
  end

  // mode 0: plain request, 1: re-pulse with new inputs mid-conversion,
  // 2: reset asserted during DESLOCA (request aborted, nothing expected)
  task automatic run_conv(input logic [7:0] a, input logic [LD-1:0] d,
                          input logic [55:0] e, input int mode);
    bit seen;
    bit occ_bad;
    int k_seen;
    @(negedge clock);
    angulo    = a;
    distancia = d;
    converter = 1'b1;
    if (mode != 2) sb_q.push_back(e);
    @(posedge clock);
    #1 converter = 1'b0;
    seen = 0; occ_bad = 0; k_seen = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      if (mode == 2 && k == 6) begin
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if ({c_a, d_a, u_a, c_d, d_d, u_d} !== {6{7'h30}} || f_a !== 7'h2C ||
            f_d !== 7'h23 || pronto !== 1'b0 || ocupado !== 1'b0) begin
          fails++;
          $display("FAIL abort_reset: got %h%h%h%h/%h%h%h%h pronto=%b ocupado=%b, required 303030 2C/303030 23 pronto=0 ocupado=0",
                   c_a, d_a, u_a, f_a, c_d, d_d, u_d, f_d, pronto, ocupado);
        end
        reset = 1'b0;
        repeat (20) @(negedge clock);
        return;
      end
      if (pronto) begin
        seen = 1; k_seen = k;
      end else if (!ocupado) begin
        occ_bad = 1;
      end
      if (mode == 1 && k == 5) begin
        angulo = 8'd1; distancia = 10'd2; converter = 1'b1;
      end
      if (mode == 1 && k == 6) converter = 1'b0;
    end
    tests++;
    if (k_seen != 12) begin
      fails++;
      $display("FAIL latency: got pronto at negedge %0d after request edge, required 12", k_seen);
    end
    tests++;
    if (occ_bad) begin
      fails++;
      $display("FAIL ocupado_busy: got ocupado=0 during conversion, required 1");
    end
    @(negedge clock);
    tests++;
    if (pronto !== 1'b0 || ocupado !== 1'b0) begin
      fails++;
      $display("FAIL after_fim: got pronto=%b ocupado=%b, required 0 0", pronto, ocupado);
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    logic [55:0] e1, e2, e3, e4, e5;
`ifdef SUPRESSAO_ZEROS_EN
    e1 = {7'h20, 7'h34, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23};
    e2 = {7'h31, 7'h38, 7'h30, 7'h2C, 7'h20, 7'h20, 7'h30, 7'h23};
    e4 = {7'h20, 7'h39, 7'h30, 7'h2C, 7'h35, 7'h30, 7'h30, 7'h23};
    e5 = {7'h20, 7'h20, 7'h37, 7'h2C, 7'h20, 7'h34, 7'h35, 7'h23};
`else
    e1 = {7'h30, 7'h34, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23};
    e2 = {7'h31, 7'h38, 7'h30, 7'h2C, 7'h30, 7'h30, 7'h30, 7'h23};
    e4 = {7'h30, 7'h39, 7'h30, 7'h2C, 7'h35, 7'h30, 7'h30, 7'h23};
    e5 = {7'h30, 7'h30, 7'h37, 7'h2C, 7'h30, 7'h34, 7'h35, 7'h23};
`endif
    e3 = {7'h32, 7'h35, 7'h35, 7'h2C, 7'h39, 7'h39, 7'h39, 7'h23};

    repeat (3) @(negedge clock);
    tests++;
    if ({c_a, d_a, u_a, c_d, d_d, u_d} !== {6{7'h30}} || f_a !== 7'h2C ||
        f_d !== 7'h23 || pronto !== 1'b0 || ocupado !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got %h%h%h%h/%h%h%h%h pronto=%b ocupado=%b, required 303030 2C/303030 23 pronto=0 ocupado=0",
               c_a, d_a, u_a, f_a, c_d, d_d, u_d, f_d, pronto, ocupado);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_conv(8'd45,  10'd123,  e1, 0);
    run_conv(8'd180, 10'd0,    e2, 0);
    run_conv(8'd255, 10'd1023, e3, 0);
    run_conv(8'd90,  10'd500,  e4, 1);
    run_conv(8'd200, 10'd300,  56'd0, 2);
    run_conv(8'd7,   10'd45,   e5, 0);

    repeat (20) @(negedge clock);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL pending: got %0d outstanding results, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
